// File: rtl/operand_stage_pkg.sv
// ============================================================================
// Module      : operand_stage_pkg
// Description : Widths, buffer state encoding and stored-entry record shared
//               by the operand stage and its bypass selector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package operand_stage_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;
  localparam int OP_W   = 3;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic [ADDR_W-1:0] src1;
    logic [ADDR_W-1:0] src2;
    logic              imm_sel;
    logic              neg_sel;
    logic [OP_W-1:0]   aluop;
    logic [ADDR_W-1:0] dest;
    logic              write_en;
  } entry_t;

  // Two's-complement negate; wraps so 0x80 stays 0x80 and 0x00 stays 0x00.
  function automatic logic [DATA_W-1:0] negate(input logic [DATA_W-1:0] v);
    negate = ~v + {{(DATA_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

`default_nettype wire

// File: rtl/operand_bypass.sv
// ============================================================================
// Module      : operand_bypass
// Description : Combinational write-back bypass and immediate selection for
//               one operand pair; used at push and to patch held entries.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module operand_bypass
  import operand_stage_pkg::*;
(
  input  logic [DATA_W-1:0] i_rd1,
  input  logic [DATA_W-1:0] i_rd2,
  input  logic [ADDR_W-1:0] i_src1,
  input  logic [ADDR_W-1:0] i_src2,
  input  logic [DATA_W-1:0] i_imm,
  input  logic              i_imm_sel,
  input  logic              i_wb_valid,
  input  logic [ADDR_W-1:0] i_wb_addr,
  input  logic [DATA_W-1:0] i_wb_data,
  output logic [DATA_W-1:0] o_op1,
  output logic [DATA_W-1:0] o_op2
);

  logic w_hit1;
  logic w_hit2;

  assign w_hit1 = i_wb_valid && (i_wb_addr == i_src1);
  assign w_hit2 = i_wb_valid && (i_wb_addr == i_src2);

  // An immediate operand never names a register, so it is never bypassed.
  assign o_op1 = w_hit1 ? i_wb_data : i_rd1;
  assign o_op2 = i_imm_sel ? i_imm : (w_hit2 ? i_wb_data : i_rd2);

endmodule

`default_nettype wire

// File: rtl/operand_stage.sv
// ============================================================================
// Module      : operand_stage
// Description : Two-entry in-order operand buffer between register read and
//               the ALU, with write-back bypass at push and on held entries.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module operand_stage #(
  parameter int DATA_W = operand_stage_pkg::DATA_W,
  parameter int ADDR_W = operand_stage_pkg::ADDR_W,
  parameter int OP_W   = operand_stage_pkg::OP_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [DATA_W-1:0] REGOUT1,
  input  logic [DATA_W-1:0] REGOUT2,
  input  logic [ADDR_W-1:0] SRC1_ADDR,
  input  logic [ADDR_W-1:0] SRC2_ADDR,
  input  logic [DATA_W-1:0] IMMEDIATE,
  input  logic              IMM_SEL,
  input  logic              NEG_SEL,
  input  logic [OP_W-1:0]   ALUOP_IN,
  input  logic [ADDR_W-1:0] DEST_IN,
  input  logic              WRITE_EN_IN,
  input  logic              WB_VALID,
  input  logic [ADDR_W-1:0] WB_ADDR,
  input  logic [DATA_W-1:0] WB_DATA,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic [DATA_W-1:0] DATA1,
  output logic [DATA_W-1:0] DATA2,
  output logic [OP_W-1:0]   ALUOP,
  output logic [ADDR_W-1:0] DEST,
  output logic              WRITE_EN
);

  import operand_stage_pkg::*;

  state_t            r_state;
  state_t            w_next_state;
  logic              r_in_ready;
  entry_t            r_ent   [2];
  entry_t            w_patch [2];
  entry_t            w_new;
  logic [DATA_W-1:0] w_new_op1;
  logic [DATA_W-1:0] w_new_op2;
  logic [DATA_W-1:0] w_p_op1 [2];
  logic [DATA_W-1:0] w_p_op2 [2];
  logic              w_push;
  logic              w_pop;
  logic              w_out_valid;

  assign w_out_valid = (r_state != EMPTY);
  assign w_push      = IN_VALID && r_in_ready;
  assign w_pop       = w_out_valid && OUT_READY;

  operand_bypass u_push_bypass (
    .i_rd1      (REGOUT1),
    .i_rd2      (REGOUT2),
    .i_src1     (SRC1_ADDR),
    .i_src2     (SRC2_ADDR),
    .i_imm      (IMMEDIATE),
    .i_imm_sel  (IMM_SEL),
    .i_wb_valid (WB_VALID),
    .i_wb_addr  (WB_ADDR),
    .i_wb_data  (WB_DATA),
    .o_op1      (w_new_op1),
    .o_op2      (w_new_op2)
  );

  // A held immediate is fed back as its own immediate so it stays put.
  for (genvar gi = 0; gi < 2; gi++) begin : g_patch
    operand_bypass u_hold_bypass (
      .i_rd1      (r_ent[gi].op1),
      .i_rd2      (r_ent[gi].op2),
      .i_src1     (r_ent[gi].src1),
      .i_src2     (r_ent[gi].src2),
      .i_imm      (r_ent[gi].op2),
      .i_imm_sel  (r_ent[gi].imm_sel),
      .i_wb_valid (WB_VALID),
      .i_wb_addr  (WB_ADDR),
      .i_wb_data  (WB_DATA),
      .o_op1      (w_p_op1[gi]),
      .o_op2      (w_p_op2[gi])
    );
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_patch[i]     = r_ent[i];
      w_patch[i].op1 = w_p_op1[i];
      w_patch[i].op2 = w_p_op2[i];
    end
    w_new          = '0;
    w_new.op1      = w_new_op1;
    w_new.op2      = w_new_op2;
    w_new.src1     = SRC1_ADDR;
    w_new.src2     = SRC2_ADDR;
    w_new.imm_sel  = IMM_SEL;
    w_new.neg_sel  = NEG_SEL;
    w_new.aluop    = ALUOP_IN;
    w_new.dest     = DEST_IN;
    w_new.write_en = WRITE_EN_IN;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      EMPTY:   if (w_push) w_next_state = ONE;
      ONE: begin
        if (w_push && !w_pop)      w_next_state = FULL;
        else if (w_pop && !w_push) w_next_state = EMPTY;
      end
      FULL:    if (w_pop) w_next_state = ONE;
      default: w_next_state = EMPTY;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state    <= EMPTY;
      r_in_ready <= 1'b1;
      r_ent[0]   <= '0;
      r_ent[1]   <= '0;
    end else begin
      r_state    <= w_next_state;
      r_in_ready <= (w_next_state != FULL);
      r_ent[0]   <= w_patch[0];
      r_ent[1]   <= w_patch[1];
      case (r_state)
        EMPTY: if (w_push) r_ent[0] <= w_new;
        ONE: begin
          if (w_push && w_pop) r_ent[0] <= w_new;
          else if (w_push)     r_ent[1] <= w_new;
        end
        FULL: begin
          if (w_pop) begin
            r_ent[0] <= w_patch[1];
            r_ent[1] <= '0;
          end
        end
        default: begin
          r_ent[0] <= '0;
          r_ent[1] <= '0;
        end
      endcase
    end
  end

  assign IN_READY  = r_in_ready;
  assign OUT_VALID = w_out_valid;
  assign DATA1     = w_out_valid ? r_ent[0].op1 : '0;
  assign DATA2     = !w_out_valid    ? '0 :
                     r_ent[0].neg_sel ? negate(r_ent[0].op2) : r_ent[0].op2;
  assign ALUOP     = w_out_valid ? r_ent[0].aluop    : '0;
  assign DEST      = w_out_valid ? r_ent[0].dest     : '0;
  assign WRITE_EN  = w_out_valid ? r_ent[0].write_en : 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_operand_stage.sv
// ============================================================================
// Module      : tb_operand_stage
// Description : Directed self-checking bench for operand_stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_operand_stage;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       IN_VALID;
  logic       IN_READY;
  logic [7:0] REGOUT1, REGOUT2, IMMEDIATE, WB_DATA;
  logic [2:0] SRC1_ADDR, SRC2_ADDR, DEST_IN, WB_ADDR, ALUOP_IN;
  logic       IMM_SEL, NEG_SEL, WRITE_EN_IN, WB_VALID;
  logic       OUT_VALID, OUT_READY;
  logic [7:0] DATA1, DATA2;
  logic [2:0] ALUOP, DEST;
  logic       WRITE_EN;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  operand_stage dut (
    .CLK(CLK), .RESET(RESET),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .REGOUT1(REGOUT1), .REGOUT2(REGOUT2),
    .SRC1_ADDR(SRC1_ADDR), .SRC2_ADDR(SRC2_ADDR),
    .IMMEDIATE(IMMEDIATE), .IMM_SEL(IMM_SEL), .NEG_SEL(NEG_SEL),
    .ALUOP_IN(ALUOP_IN), .DEST_IN(DEST_IN), .WRITE_EN_IN(WRITE_EN_IN),
    .WB_VALID(WB_VALID), .WB_ADDR(WB_ADDR), .WB_DATA(WB_DATA),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .DATA1(DATA1), .DATA2(DATA2), .ALUOP(ALUOP), .DEST(DEST),
    .WRITE_EN(WRITE_EN)
  );

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_entry(input logic [7:0] r1, input logic [7:0] r2,
                           input logic [2:0] s1, input logic [2:0] s2,
                           input logic neg, input logic [2:0] op,
                           input logic [2:0] dst, input logic we);
    REGOUT1 = r1; REGOUT2 = r2; SRC1_ADDR = s1; SRC2_ADDR = s2;
    NEG_SEL = neg; ALUOP_IN = op; DEST_IN = dst; WRITE_EN_IN = we;
    IMM_SEL = 1'b0; IMMEDIATE = 8'h00;
  endtask

  task automatic test_reset();
    RESET = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0; WB_VALID = 1'b0;
    WB_ADDR = 3'd0; WB_DATA = 8'h00;
    set_entry(8'h00, 8'h00, 3'd0, 3'd0, 1'b0, 3'd0, 3'd0, 1'b0);
    cyc(); cyc();
    n_cmp++; if (OUT_VALID !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", OUT_VALID); end
    n_cmp++; if (IN_READY !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b expected 1", IN_READY); end
    n_cmp++; if ({DATA1, DATA2, ALUOP, DEST, WRITE_EN} !== 23'd0) begin n_err++;
      $display("FAIL reset_data: got %h %h %h %h %b expected all zero", DATA1, DATA2, ALUOP, DEST, WRITE_EN); end
    RESET = 1'b1;
  endtask

  task automatic test_neg_basic();
    set_entry(8'h05, 8'h03, 3'd1, 3'd2, 1'b1, 3'd2, 3'd5, 1'b1);
    IN_VALID = 1'b1; OUT_READY = 1'b1;
    cyc();
    IN_VALID = 1'b0;
    n_cmp++; if (OUT_VALID !== 1'b1) begin n_err++; $display("FAIL neg_out_valid: got %b expected 1", OUT_VALID); end
    n_cmp++; if (DATA1 !== 8'h05) begin n_err++; $display("FAIL neg_data1: got %h expected 05", DATA1); end
    n_cmp++; if (DATA2 !== 8'hFD) begin n_err++; $display("FAIL neg_data2: got %h expected fd", DATA2); end
    n_cmp++; if ({ALUOP, DEST, WRITE_EN} !== {3'd2, 3'd5, 1'b1}) begin n_err++;
      $display("FAIL neg_ctrl: got %h %h %b expected 2 5 1", ALUOP, DEST, WRITE_EN); end
    cyc();
    n_cmp++; if (OUT_VALID !== 1'b0 || DATA2 !== 8'h00) begin n_err++;
      $display("FAIL neg_drained: got valid %b data2 %h expected 0 00", OUT_VALID, DATA2); end
  endtask

  task automatic test_back_to_back();
    OUT_READY = 1'b0; IN_VALID = 1'b1;
    set_entry(8'h10, 8'h01, 3'd1, 3'd2, 1'b0, 3'd1, 3'd1, 1'b1);
    cyc();
    n_cmp++; if (IN_READY !== 1'b1) begin n_err++; $display("FAIL b2b_ready_one: got %b expected 1", IN_READY); end
    set_entry(8'h20, 8'h02, 3'd1, 3'd2, 1'b0, 3'd2, 3'd2, 1'b1);
    cyc();
    n_cmp++; if (IN_READY !== 1'b0) begin n_err++; $display("FAIL b2b_ready_full: got %b expected 0", IN_READY); end
    set_entry(8'h30, 8'h03, 3'd1, 3'd2, 1'b0, 3'd3, 3'd3, 1'b1);
    cyc();
    IN_VALID = 1'b0;
    n_cmp++; if (IN_READY !== 1'b0 || DATA1 !== 8'h10) begin n_err++;
      $display("FAIL b2b_stalled: got ready %b data1 %h expected 0 10", IN_READY, DATA1); end
    OUT_READY = 1'b1;
    cyc();
    n_cmp++; if (DATA1 !== 8'h20 || DEST !== 3'd2) begin n_err++;
      $display("FAIL b2b_second: got data1 %h dest %h expected 20 2", DATA1, DEST); end
    n_cmp++; if (IN_READY !== 1'b1) begin n_err++; $display("FAIL b2b_ready_back: got %b expected 1", IN_READY); end
    cyc();
    n_cmp++; if (OUT_VALID !== 1'b0) begin n_err++; $display("FAIL b2b_third_dropped: got valid %b expected 0", OUT_VALID); end
    OUT_READY = 1'b0;
  endtask

  task automatic test_bypass_push();
    OUT_READY = 1'b0; IN_VALID = 1'b1;
    set_entry(8'h01, 8'h11, 3'd0, 3'd2, 1'b0, 3'd0, 3'd3, 1'b0);
    WB_VALID = 1'b1; WB_ADDR = 3'd2; WB_DATA = 8'h44;
    cyc();
    IN_VALID = 1'b0; WB_VALID = 1'b0;
    n_cmp++; if (DATA2 !== 8'h44 || DATA1 !== 8'h01) begin n_err++;
      $display("FAIL bypass_src2: got data1 %h data2 %h expected 01 44", DATA1, DATA2); end
    OUT_READY = 1'b1; cyc(); OUT_READY = 1'b0;
    IN_VALID = 1'b1;
    set_entry(8'h01, 8'h11, 3'd0, 3'd2, 1'b0, 3'd0, 3'd3, 1'b0);
    IMM_SEL = 1'b1; IMMEDIATE = 8'h07;
    WB_VALID = 1'b1; WB_ADDR = 3'd2; WB_DATA = 8'h44;
    cyc();
    IN_VALID = 1'b0; WB_DATA = 8'h55;
    n_cmp++; if (DATA2 !== 8'h07) begin n_err++; $display("FAIL bypass_imm: got %h expected 07", DATA2); end
    cyc();
    WB_VALID = 1'b0;
    n_cmp++; if (DATA2 !== 8'h07) begin n_err++; $display("FAIL bypass_imm_held: got %h expected 07", DATA2); end
    OUT_READY = 1'b1; cyc(); OUT_READY = 1'b0;
  endtask

  task automatic test_patch_held();
    OUT_READY = 1'b0; IN_VALID = 1'b1;
    set_entry(8'h12, 8'h01, 3'd4, 3'd0, 1'b0, 3'd1, 3'd6, 1'b1);
    cyc();
    n_cmp++; if (DATA1 !== 8'h12) begin n_err++; $display("FAIL patch_before: got %h expected 12", DATA1); end
    set_entry(8'h33, 8'h02, 3'd1, 3'd4, 1'b0, 3'd2, 3'd7, 1'b1);
    cyc();
    IN_VALID = 1'b0;
    WB_VALID = 1'b1; WB_ADDR = 3'd4; WB_DATA = 8'h9A;
    cyc();
    WB_VALID = 1'b0;
    n_cmp++; if (OUT_VALID !== 1'b1 || DATA1 !== 8'h9A || DATA2 !== 8'h01) begin n_err++;
      $display("FAIL patch_head: got valid %b data1 %h data2 %h expected 1 9a 01", OUT_VALID, DATA1, DATA2); end
    OUT_READY = 1'b1;
    cyc();
    n_cmp++; if (DATA1 !== 8'h33 || DATA2 !== 8'h9A) begin n_err++;
      $display("FAIL patch_second: got data1 %h data2 %h expected 33 9a", DATA1, DATA2); end
    cyc();
    OUT_READY = 1'b0;
  endtask

  task automatic test_push_pop();
    OUT_READY = 1'b1; IN_VALID = 1'b1;
    set_entry(8'h21, 8'h00, 3'd1, 3'd2, 1'b0, 3'd3, 3'd1, 1'b1);
    cyc();
    n_cmp++; if (DATA1 !== 8'h21) begin n_err++; $display("FAIL pp_first: got %h expected 21", DATA1); end
    set_entry(8'h22, 8'h00, 3'd1, 3'd2, 1'b0, 3'd4, 3'd2, 1'b1);
    cyc();
    IN_VALID = 1'b0;
    n_cmp++; if (OUT_VALID !== 1'b1 || DATA1 !== 8'h22 || ALUOP !== 3'd4) begin n_err++;
      $display("FAIL pp_no_bubble: got valid %b data1 %h aluop %h expected 1 22 4", OUT_VALID, DATA1, ALUOP); end
    cyc();
    n_cmp++; if (OUT_VALID !== 1'b0) begin n_err++; $display("FAIL pp_empty: got %b expected 0", OUT_VALID); end
    OUT_READY = 1'b0;
  endtask

  task automatic test_reset_full_and_neg_edges();
    OUT_READY = 1'b0; IN_VALID = 1'b1;
    set_entry(8'h41, 8'h00, 3'd1, 3'd2, 1'b0, 3'd1, 3'd1, 1'b1);
    cyc();
    set_entry(8'h42, 8'h00, 3'd1, 3'd2, 1'b0, 3'd1, 3'd1, 1'b1);
    cyc();
    IN_VALID = 1'b0;
    n_cmp++; if (IN_READY !== 1'b0) begin n_err++; $display("FAIL rst_full_pre: got ready %b expected 0", IN_READY); end
    #2 RESET = 1'b0;
    #1;
    n_cmp++; if (OUT_VALID !== 1'b0 || IN_READY !== 1'b1 || DATA1 !== 8'h00) begin n_err++;
      $display("FAIL rst_async: got valid %b ready %b data1 %h expected 0 1 00", OUT_VALID, IN_READY, DATA1); end
    cyc();
    RESET = 1'b1;
    cyc();
    n_cmp++; if (OUT_VALID !== 1'b0) begin n_err++; $display("FAIL rst_no_stale: got %b expected 0", OUT_VALID); end
    OUT_READY = 1'b1; IN_VALID = 1'b1;
    set_entry(8'h5A, 8'h80, 3'd1, 3'd2, 1'b1, 3'd1, 3'd1, 1'b1);
    cyc();
    n_cmp++; if (DATA2 !== 8'h80) begin n_err++; $display("FAIL neg_0x80: got %h expected 80", DATA2); end
    set_entry(8'h5B, 8'h00, 3'd1, 3'd2, 1'b1, 3'd1, 3'd1, 1'b1);
    cyc();
    IN_VALID = 1'b0;
    n_cmp++; if (OUT_VALID !== 1'b1 || DATA1 !== 8'h5B || DATA2 !== 8'h00) begin n_err++;
      $display("FAIL neg_0x00: got valid %b data1 %h data2 %h expected 1 5b 00", OUT_VALID, DATA1, DATA2); end
    cyc();
    OUT_READY = 1'b0;
  endtask

  initial begin
    test_reset();
    test_neg_basic();
    test_back_to_back();
    test_bypass_push();
    test_patch_held();
    test_push_pop();
    test_reset_full_and_neg_edges();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
